// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_if
// Brief    : IFU bus bundle: IM request/response, redirect controls, IF/ID out.
// Revision : 1.0  initial release
// ============================================================================
interface ifu_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_adel;

  // Fetch-unit side.
  modport master (
    input  stall, branch_taken, branch_target, exc_req, eret, epc, im_instr,
    output im_addr, pc, if_pc, if_instr, if_valid, if_adel
  );

  // Pipeline / IM side.
  modport slave (
    output stall, branch_taken, branch_target, exc_req, eret, epc, im_instr,
    input  im_addr, pc, if_pc, if_instr, if_valid, if_adel
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch: PC register, IM addressing, IF/ID capture.
//            Optional fetch address check enabled by IFU_ADDR_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          TEXT_WORDS = 2048
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  ifu_fetch_if.master bus
);

`ifdef IFU_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // 33-bit bound so a text segment ending at 2^32 cannot wrap to zero.
  localparam logic [32:0] TEXT_END = {1'b0, RESET_PC} + 33'(4 * TEXT_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        if_adel_q, if_adel_d;

  logic        fetch_fault;
  logic [31:0] fetch_word;

  always_comb begin
    fetch_fault = ADDR_CHECK &&
                  ((pc_q[1:0] != 2'b00) ||
                   (pc_q < RESET_PC) ||
                   ({1'b0, pc_q} >= TEXT_END));
    fetch_word  = fetch_fault ? 32'h0 : bus.im_instr;
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if_adel_d  = if_adel_q;

    if (bus.exc_req || bus.eret) begin
      // Exception beats eret; both flush IF/ID regardless of stall.
      pc_d       = bus.exc_req ? EXC_VECTOR : bus.epc;
      if_pc_d    = 32'h0;
      if_instr_d = 32'h0;
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = bus.branch_taken ? bus.branch_target : pc_q + 32'd4;
      if_pc_d    = pc_q;
      if_instr_d = fetch_word;
      if_valid_d = 1'b1;
      if_adel_d  = fetch_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      if_valid_q <= 1'b0;
      if_adel_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      if_adel_q  <= if_adel_d;
    end
  end

  assign bus.im_addr  = pc_q;
  assign bus.pc       = pc_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_adel  = if_adel_q;

endmodule
`default_nettype wire
